// File: rtl/alu_seq_core.sv
// ============================================================================
// Module   : alu_seq_core
// Brief    : Handshaked sequential ALU with registered result/flags, bit-serial
//            shifts, shift-add multiply and a chaining accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_SHL = 3'b100;
  localparam logic [2:0] c_OP_SHR = 3'b101;
  localparam logic [2:0] c_OP_MUL = 3'b110;
  localparam logic [2:0] c_OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [2:0]             r_op;
  logic [WIDTH-1:0]       r_sh;
  logic [WIDTH-1:0]       r_mcand;
  logic [2*WIDTH-1:0]     r_prod;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_acc;
  logic [WIDTH-1:0]       r_result;
  logic [3:0]             r_flags;

  logic                   w_accept;
  logic [WIDTH-1:0]       w_opa;
  logic [SHW-1:0]         w_shamt;
  logic [WIDTH:0]         w_add;
  logic [WIDTH:0]         w_sub;
  logic [WIDTH-1:0]       w_sh_nx;
  logic                   w_sh_c;
  logic [WIDTH:0]         w_madd;
  logic [2*WIDTH-1:0]     w_prod_nx;
  logic                   w_fin;
  logic [WIDTH-1:0]       w_fin_res;
  logic                   w_fin_c;
  logic                   w_fin_v;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_opa    = use_acc ? r_acc : a;
  assign w_shamt  = b[SHW-1:0];
  assign w_add    = {1'b0, w_opa} + {1'b0, b};
  assign w_sub    = {1'b0, w_opa} - {1'b0, b};

  assign w_sh_nx  = (r_op == c_OP_SHL) ? (r_sh << 1) : (r_sh >> 1);
  assign w_sh_c   = (r_op == c_OP_SHL) ? r_sh[WIDTH-1] : r_sh[0];

  // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
  assign w_madd    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  assign w_prod_nx = r_prod[0] ? {w_madd, r_prod[WIDTH-1:1]}
                               : {1'b0, r_prod[2*WIDTH-1:1]};

  always_comb begin
    w_state_nx = r_state;
    w_fin      = 1'b0;
    w_fin_res  = '0;
    w_fin_c    = 1'b0;
    w_fin_v    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op)
            c_OP_ADD: begin
              w_fin     = 1'b1;
              w_fin_res = w_add[WIDTH-1:0];
              w_fin_c   = w_add[WIDTH];
              w_fin_v   = (w_opa[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != w_opa[WIDTH-1]);
            end
            c_OP_SUB: begin
              w_fin     = 1'b1;
              w_fin_res = w_sub[WIDTH-1:0];
              w_fin_c   = w_sub[WIDTH];
              w_fin_v   = (w_opa[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != w_opa[WIDTH-1]);
            end
            c_OP_AND: begin
              w_fin     = 1'b1;
              w_fin_res = w_opa & b;
            end
            c_OP_OR: begin
              w_fin     = 1'b1;
              w_fin_res = w_opa | b;
            end
            c_OP_XOR: begin
              w_fin     = 1'b1;
              w_fin_res = w_opa ^ b;
            end
            c_OP_SHL, c_OP_SHR: begin
              if (w_shamt == '0) begin
                w_fin     = 1'b1;
                w_fin_res = w_opa;
              end else begin
                w_state_nx = S_EXEC;
              end
            end
            default: w_state_nx = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        if (r_cnt == CW'(1)) begin
          w_fin = 1'b1;
          if (r_op == c_OP_MUL) begin
            w_fin_res = w_prod_nx[WIDTH-1:0];
            w_fin_c   = |w_prod_nx[2*WIDTH-1:WIDTH];
          end else begin
            w_fin_res = w_sh_nx;
            w_fin_c   = w_sh_c;
          end
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_fin) w_state_nx = S_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sh     <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_op    <= op;
        r_sh    <= w_opa;
        r_mcand <= w_opa;
        r_prod  <= {{WIDTH{1'b0}}, b};
        r_cnt   <= (op == c_OP_MUL) ? CW'(WIDTH) : CW'(w_shamt);
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_op == c_OP_MUL) r_prod <= w_prod_nx;
        else                  r_sh   <= w_sh_nx;
      end
      if (w_fin) begin
        r_result <= w_fin_res;
        r_flags  <= {w_fin_c, w_fin_v, w_fin_res[WIDTH-1], (w_fin_res == '0)};
        r_acc    <= w_fin_res;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

`default_nettype wire
